syn_branch_predictor: RTL and testbench
=======================================

SYN_BRANCH_PREDICTOR -- requirements
Module: syn_branch_predictor

Interface
REQ-001 The block SHALL have parameter IM_ADDR_BIT, default 10, giving the word-address width of the instruction memory.
REQ-002 The block SHALL have parameter IDX_BITS, default 3, giving the table index width (ENTRIES = 2**IDX_BITS).
REQ-003 The block SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port en, input, 1 bit: global enable; all state changes are gated by it.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous invalidate of all entries.
REQ-007 The block SHALL have port lookup_pc, input, IM_ADDR_BIT bits: word address of the instruction being fetched.
REQ-008 The block SHALL have port pred_taken, output, 1 bit: taken prediction for lookup_pc.
REQ-009 The block SHALL have port pred_pc, output, IM_ADDR_BIT bits: predicted next fetch word address.
REQ-010 The block SHALL have port upd_en, input, 1 bit: a resolved jump/branch is presented this cycle.
REQ-011 The block SHALL have port upd_pc, input, IM_ADDR_BIT bits: word address of the resolved instruction.
REQ-012 The block SHALL have port upd_taken, input, 1 bit: actual direction of the resolved instruction.
REQ-013 The block SHALL have port upd_target, input, IM_ADDR_BIT bits: actual target when taken.
REQ-014 The block SHALL have port upd_mispred, input, 1 bit: the resolving stage flagged a misprediction.
REQ-015 The block SHALL have port stat_lookups, output, 16 bits: count of accepted updates.
REQ-016 The block SHALL have port stat_mispreds, output, 16 bits: count of accepted mispredicted updates.

Function
REQ-017 Each entry SHALL hold valid, tag (IM_ADDR_BIT-IDX_BITS bits), target (IM_ADDR_BIT bits) and a 2-bit saturating counter ctr.
REQ-018 Lookup SHALL be combinational: idx = lookup_pc[IDX_BITS-1:0]; hit = valid[idx] && tag[idx] == lookup_pc[IM_ADDR_BIT-1:IDX_BITS].
REQ-019 pred_taken SHALL equal hit && ctr[idx][1]; pred_pc SHALL equal target[idx] when pred_taken, else lookup_pc+1 modulo 2**IM_ADDR_BIT (all-ones wraps to 0).
REQ-020 An update SHALL be accepted on a rising edge with en && upd_en && !flush.
REQ-021 On an accepted update that hits: ctr SHALL increment (saturating at 3) when upd_taken, else decrement (saturating at 0); target SHALL be overwritten with upd_target when upd_taken.
REQ-022 On an accepted update that misses with upd_taken=1: the entry SHALL be allocated (replacing any occupant) with valid=1, new tag, target=upd_target, ctr=2'b10.
REQ-023 On an accepted update that misses with upd_taken=0: the table SHALL be unchanged.
REQ-024 When lookup and update address the same index in one cycle, the lookup SHALL see pre-update contents (no bypass).
REQ-025 With en && flush on a rising edge, all valid bits SHALL clear; flush has priority over a simultaneous update; statistics are retained.
REQ-026 With en=0, no table or statistic state SHALL change; lookup outputs stay live.
REQ-027 stat_lookups SHALL increment on each accepted update; stat_mispreds SHALL increment on each accepted update with upd_mispred=1; both saturate at 16'hFFFF.

Reset
REQ-028 On rst_n low, all valid bits, ctr fields, stat_lookups and stat_mispreds SHALL clear to 0 immediately; tag/target need no reset.
REQ-029 During and after reset, pred_taken SHALL be 0 and pred_pc SHALL be lookup_pc+1.
REQ-030 Reset asserted mid-update SHALL discard that update.

Structure
REQ-031 The shared Core include SHALL own IM_ADDR_BIT and the counter encodings (strong/weak not-taken/taken: 0..3).
REQ-032 One sub-module, cmb_sat_counter2 (2-bit saturating up/down next-state), SHALL be used per update path.
REQ-033 Table storage SHALL be flip-flop arrays, not RAM macros, for single-cycle combinational read.

Verification
REQ-034 Reset, lookup_pc=10'h3FF -> pred_taken=0, pred_pc=10'h000.
REQ-035 Update pc=0x012, taken=1, target=0x040 -> next cycle lookup 0x012 gives pred_taken=1, pred_pc=0x040; lookup 0x01A (same idx, other tag) gives pred_taken=0, pred_pc=0x01B.
REQ-036 Three not-taken updates of 0x012 after allocation -> ctr 2->1->0->0, pred_taken=0 after first; two taken updates -> pred_taken=1 again.
REQ-037 Same-cycle update (allocate 0x005) and lookup 0x005 -> that cycle pred_taken=0; following cycle pred_taken=1.
REQ-038 flush together with upd_en -> all lookups miss, stat_lookups unchanged; en=0 with upd_en -> no change.
REQ-039 70000 accepted updates with upd_mispred=1 -> both statistics hold 16'hFFFF.

Source files
------------

// File: rtl/syn_branch_predictor_pkg.sv
// Shared definitions for the branch predictor: default address width,
// 2-bit counter encodings and statistics width.
package syn_branch_predictor_pkg;

    localparam int unsigned IM_ADDR_BIT = 10;
    localparam int unsigned CTR_W       = 2;
    localparam int unsigned STAT_W      = 16;

    typedef enum logic [CTR_W-1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } ctr_e;

endpackage

// File: rtl/cmb_sat_counter2.sv
// Next-state logic for a 2-bit saturating up/down direction counter.
module cmb_sat_counter2
    import syn_branch_predictor_pkg::*;
(
    input  logic [CTR_W-1:0] ctr,
    input  logic             inc,
    output logic [CTR_W-1:0] ctr_nxt_c
);

    always_comb begin
        ctr_nxt_c = ctr;
        if (inc) begin
            if (ctr != CTR_W'(CTR_ST)) ctr_nxt_c = ctr + CTR_W'(1);
        end else begin
            if (ctr != CTR_W'(CTR_SNT)) ctr_nxt_c = ctr - CTR_W'(1);
        end
    end

endmodule

// File: rtl/syn_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters,
// combinational lookup and single-port update path with statistics.
module syn_branch_predictor #(
    parameter int unsigned IM_ADDR_BIT = syn_branch_predictor_pkg::IM_ADDR_BIT,
    parameter int unsigned IDX_BITS    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   flush,
    input  logic [IM_ADDR_BIT-1:0] lookup_pc,
    output logic                   pred_taken,
    output logic [IM_ADDR_BIT-1:0] pred_pc,
    input  logic                   upd_en,
    input  logic [IM_ADDR_BIT-1:0] upd_pc,
    input  logic                   upd_taken,
    input  logic [IM_ADDR_BIT-1:0] upd_target,
    input  logic                   upd_mispred,
    output logic [syn_branch_predictor_pkg::STAT_W-1:0] stat_lookups,
    output logic [syn_branch_predictor_pkg::STAT_W-1:0] stat_mispreds
);
    import syn_branch_predictor_pkg::*;

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int unsigned TAG_W   = IM_ADDR_BIT - IDX_BITS;

    logic [ENTRIES-1:0]     valid_q;
    logic [CTR_W-1:0]       ctr_q    [ENTRIES];
    logic [TAG_W-1:0]       tag_q    [ENTRIES];
    logic [IM_ADDR_BIT-1:0] target_q [ENTRIES];

    logic [IDX_BITS-1:0] l_idx;
    logic [IDX_BITS-1:0] u_idx;
    logic [TAG_W-1:0]    l_tag;
    logic [TAG_W-1:0]    u_tag;
    logic                l_hit;
    logic                u_hit;
    logic                upd_acc;
    logic [CTR_W-1:0]    ctr_nxt_c;

    // Lookup reads current table contents; same-cycle updates are not bypassed.
    assign l_idx      = lookup_pc[IDX_BITS-1:0];
    assign l_tag      = lookup_pc[IM_ADDR_BIT-1:IDX_BITS];
    assign l_hit      = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign pred_taken = l_hit && ctr_q[l_idx][1];
    assign pred_pc    = pred_taken ? target_q[l_idx] : lookup_pc + IM_ADDR_BIT'(1);

    assign u_idx   = upd_pc[IDX_BITS-1:0];
    assign u_tag   = upd_pc[IM_ADDR_BIT-1:IDX_BITS];
    assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign upd_acc = en && upd_en && !flush;

    cmb_sat_counter2 u_ctr (
        .ctr       (ctr_q[u_idx]),
        .inc       (upd_taken),
        .ctr_nxt_c (ctr_nxt_c)
    );

    // Valid bits and counters; flush wins over a concurrent update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_W'(CTR_SNT);
            end
        end else if (en) begin
            if (flush) begin
                valid_q <= '0;
            end else if (upd_en) begin
                if (u_hit) begin
                    ctr_q[u_idx] <= ctr_nxt_c;
                end else if (upd_taken) begin
                    valid_q[u_idx] <= 1'b1;
                    ctr_q[u_idx]   <= CTR_W'(CTR_WT);
                end
            end
        end
    end

    // Tag/target payload carries no reset; valid bits qualify it.
    always_ff @(posedge clk) begin
        if (upd_acc && upd_taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= upd_target;
        end
    end

    // Saturating statistics of accepted updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups  <= '0;
            stat_mispreds <= '0;
        end else if (upd_acc) begin
            if (stat_lookups != '1) stat_lookups <= stat_lookups + STAT_W'(1);
            if (upd_mispred && (stat_mispreds != '1)) stat_mispreds <= stat_mispreds + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_syn_branch_predictor.sv
// Directed vector bench for syn_branch_predictor: table of per-cycle
// stimulus with expected pre-edge outputs, plus reset and saturation sequences.
module tb_syn_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic [9:0]  lookup_pc;
    logic        pred_taken;
    logic [9:0]  pred_pc;
    logic        upd_en;
    logic [9:0]  upd_pc;
    logic        upd_taken;
    logic [9:0]  upd_target;
    logic        upd_mispred;
    logic [15:0] stat_lookups;
    logic [15:0] stat_mispreds;

    int n_vec;
    int n_bad;

    syn_branch_predictor #(.IM_ADDR_BIT(10), .IDX_BITS(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .flush         (flush),
        .lookup_pc     (lookup_pc),
        .pred_taken    (pred_taken),
        .pred_pc       (pred_pc),
        .upd_en        (upd_en),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_mispred   (upd_mispred),
        .stat_lookups  (stat_lookups),
        .stat_mispreds (stat_mispreds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        flush;
        logic        upd_en;
        logic [9:0]  upd_pc;
        logic        upd_taken;
        logic [9:0]  upd_target;
        logic        upd_mispred;
        logic [9:0]  lookup_pc;
        logic        exp_taken;
        logic [9:0]  exp_pc;
        logic [15:0] exp_look;
        logic [15:0] exp_mis;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic e, input logic f, input logic u,
                                input logic [9:0] upc, input logic ut,
                                input logic [9:0] utg, input logic um,
                                input logic [9:0] lpc, input logic xt,
                                input logic [9:0] xpc, input logic [15:0] xl,
                                input logic [15:0] xm);
        vec_t v;
        v.en = e; v.flush = f; v.upd_en = u; v.upd_pc = upc; v.upd_taken = ut;
        v.upd_target = utg; v.upd_mispred = um; v.lookup_pc = lpc;
        v.exp_taken = xt; v.exp_pc = xpc; v.exp_look = xl; v.exp_mis = xm;
        return v;
    endfunction

    task automatic check(input string name, input int id,
                         input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %h expected %h", name, id, act, exp);
        end
    endtask

    task automatic check_outputs(input int id, input logic xt, input logic [9:0] xpc,
                                 input logic [15:0] xl, input logic [15:0] xm);
        check("pred_taken", id, 16'(pred_taken), 16'(xt));
        check("pred_pc", id, 16'(pred_pc), 16'(xpc));
        check("stat_lookups", id, stat_lookups, xl);
        check("stat_mispreds", id, stat_mispreds, xm);
    endtask

    task automatic idle_inputs();
        en = 1'b1; flush = 1'b0; upd_en = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_mispred = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        //            en f  u  upd_pc   t  target   m  lookup   xt xpc      look mis
        vecs[0]  = mk(1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h3FF, 0, 10'h000, 0,  0);
        vecs[1]  = mk(1, 0, 1, 10'h012, 1, 10'h040, 1, 10'h012, 0, 10'h013, 0,  0);
        vecs[2]  = mk(1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h012, 1, 10'h040, 1,  1);
        vecs[3]  = mk(1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h01A, 0, 10'h01B, 1,  1);
        vecs[4]  = mk(1, 0, 1, 10'h012, 0, 10'h000, 1, 10'h012, 1, 10'h040, 1,  1);
        vecs[5]  = mk(1, 0, 1, 10'h012, 0, 10'h000, 0, 10'h012, 0, 10'h013, 2,  2);
        vecs[6]  = mk(1, 0, 1, 10'h012, 0, 10'h000, 0, 10'h012, 0, 10'h013, 3,  2);
        vecs[7]  = mk(1, 0, 1, 10'h012, 1, 10'h050, 0, 10'h012, 0, 10'h013, 4,  2);
        vecs[8]  = mk(1, 0, 1, 10'h012, 1, 10'h060, 0, 10'h012, 0, 10'h013, 5,  2);
        vecs[9]  = mk(1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h012, 1, 10'h060, 6,  2);
        vecs[10] = mk(1, 0, 1, 10'h01A, 0, 10'h000, 1, 10'h012, 1, 10'h060, 6,  2);
        vecs[11] = mk(1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h012, 1, 10'h060, 7,  3);
        vecs[12] = mk(1, 0, 1, 10'h005, 1, 10'h100, 0, 10'h005, 0, 10'h006, 7,  3);
        vecs[13] = mk(1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h005, 1, 10'h100, 8,  3);
        vecs[14] = mk(0, 0, 1, 10'h012, 1, 10'h070, 1, 10'h012, 1, 10'h060, 8,  3);
        vecs[15] = mk(1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h012, 1, 10'h060, 8,  3);
        vecs[16] = mk(0, 1, 0, 10'h000, 0, 10'h000, 0, 10'h005, 1, 10'h100, 8,  3);
        vecs[17] = mk(1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h005, 1, 10'h100, 8,  3);
        vecs[18] = mk(1, 1, 1, 10'h012, 1, 10'h070, 1, 10'h005, 1, 10'h100, 8,  3);
        vecs[19] = mk(1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h005, 0, 10'h006, 8,  3);
        vecs[20] = mk(1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h012, 0, 10'h013, 8,  3);
        vecs[21] = mk(1, 0, 1, 10'h012, 1, 10'h020, 0, 10'h3FF, 0, 10'h000, 8,  3);
        vecs[22] = mk(1, 0, 1, 10'h01A, 1, 10'h0AA, 0, 10'h012, 1, 10'h020, 9,  3);
        vecs[23] = mk(1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h012, 0, 10'h013, 10, 3);
        vecs[24] = mk(1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h01A, 1, 10'h0AA, 10, 3);
        vecs[25] = mk(1, 0, 1, 10'h01A, 1, 10'h0AA, 0, 10'h01A, 1, 10'h0AA, 10, 3);
        vecs[26] = mk(1, 0, 1, 10'h01A, 1, 10'h0AA, 0, 10'h01A, 1, 10'h0AA, 11, 3);
        vecs[27] = mk(1, 0, 1, 10'h01A, 0, 10'h000, 0, 10'h01A, 1, 10'h0AA, 12, 3);
        vecs[28] = mk(1, 0, 1, 10'h01A, 0, 10'h000, 0, 10'h01A, 1, 10'h0AA, 13, 3);
        vecs[29] = mk(1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h01A, 0, 10'h01B, 14, 3);

        // Outputs during reset
        idle_inputs();
        rst_n     = 1'b0;
        lookup_pc = 10'h3FF;
        #3;
        check_outputs(100, 1'b0, 10'h000, 16'd0, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven vectors: outputs compared before the edge applies the update
        for (int i = 0; i < NV; i++) begin
            en = vecs[i].en; flush = vecs[i].flush; upd_en = vecs[i].upd_en;
            upd_pc = vecs[i].upd_pc; upd_taken = vecs[i].upd_taken;
            upd_target = vecs[i].upd_target; upd_mispred = vecs[i].upd_mispred;
            lookup_pc = vecs[i].lookup_pc;
            #1;
            check_outputs(i, vecs[i].exp_taken, vecs[i].exp_pc,
                          vecs[i].exp_look, vecs[i].exp_mis);
            @(posedge clk);
            #1;
        end

        // Async reset asserted while an allocating update is pending
        idle_inputs();
        upd_en = 1'b1; upd_pc = 10'h005; upd_taken = 1'b1;
        upd_target = 10'h200; upd_mispred = 1'b1;
        lookup_pc = 10'h01A;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs(200, 1'b0, 10'h01B, 16'd0, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_inputs();
        lookup_pc = 10'h005;
        #1;
        check_outputs(201, 1'b0, 10'h006, 16'd0, 16'd0);

        // Statistics saturation over 70000 accepted mispredicted updates
        upd_en = 1'b1; upd_pc = 10'h3FF; upd_taken = 1'b0; upd_mispred = 1'b1;
        lookup_pc = 10'h3FF;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        check_outputs(300, 1'b0, 10'h000, 16'hFFFF, 16'hFFFF);
        upd_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
